td4x_datapath: RTL
==================

# td4x_datapath

Parametrised register-file/ALU/program-counter datapath for the next-generation TD4 core. Replaces the fixed 4-bit, two-register, add-only datapath with configurable data width, register count and PC width. Adds SUB/AND/OR, a zero flag, conditional writes and a cycle enable. Sits between the instruction decoder (which drives select, op and condition fields) and the ROM address bus / output port.

## Interface
Parameters:
- WIDTH, 4, data path width; legal range 4..16.
- NREGS, 2, number of general-purpose registers; legal range 2..8.
- PC_W, 4, program counter width; legal range 4..12.
- SEL_W, $clog2(NREGS+2), width of the source and destination selects; derived, not overridable.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- CLR_N  in  1  reset, asynchronous, active-low.
- EN  in  1  cycle enable; 0 holds all state.
- SRC  in  SEL_W  operand source: 0..NREGS-1 = register, NREGS = IN, NREGS+1 = constant 0.
- DST  in  SEL_W  write target: 0..NREGS-1 = register, NREGS = OUT register, NREGS+1 = PC.
- WE  in  1  write request.
- ALU_OP  in  2  operation: 0 ADD, 1 SUB, 2 AND, 3 OR; second operand is always IMMED.
- COND  in  2  write condition: 0 always, 1 carry clear (JNC), 2 zero set, 3 zero clear.
- IN  in  WIDTH  external input port.
- IMMED  in  WIDTH  immediate operand.
- OUT  out  WIDTH  output port register.
- PC  out  PC_W  ROM address.
- CARRY_N  out  1  registered inverted carry flag.
- ZERO  out  1  registered zero flag.

## Operation
- Operand A is selected by SRC; any SRC value above NREGS+1 reads 0.
- The result is WIDTH+1 bits. ADD: A+IMMED. SUB: A+~IMMED+1, so the carry bit is 1 when A>=IMMED (no borrow). AND/OR: carry = 0.
- The write is taken when WE=1, EN=1 and COND is satisfied by the current registered flags, i.e. the flags produced by the previous enabled cycle.
- A taken write stores result[WIDTH-1:0] into the DST target.
  - PC target: result truncated to PC_W bits if WIDTH>PC_W, zero-extended otherwise.
  - DST above NREGS+1: the write is dropped.
- PC behaviour:
  - If a taken write targets the PC, the written value replaces the increment.
  - Otherwise PC <= PC+1 mod 2^PC_W on every enabled cycle, including cycles with a dropped or failed conditional write.
- Flags update on every enabled cycle regardless of WE or COND:
  - CARRY_N <= ~carry.
  - ZERO <= (result[WIDTH-1:0]==0).
- EN=0: no register, OUT, PC or flag changes.
- Reset values: all registers 0, OUT=0, PC=0, CARRY_N=1, ZERO=0.

## Timing
- Single-cycle: operand select and ALU are combinational; every state element updates on the rising CLK edge after inputs settle.
- OUT, PC, CARRY_N and ZERO are direct register outputs with no combinational path from any input.
- A write-then-read of the same register needs two cycles; there is no forwarding.
- A conditional write in cycle n uses the flags written at edge n-1.
- CLR_N low forces reset values immediately, independent of CLK. This applies mid-instruction and with EN high.
- Release of CLR_N takes effect at the first rising edge where CLR_N is high. External synchronisation of the deassertion is the integrator's responsibility.
- Simultaneous events:
  - A write to a register or OUT and the PC increment happen on the same edge.
  - A write to the PC suppresses the increment on that edge only.

## Structure
- Package td4x_pkg holds:
  - alu_op_t enum (ADD, SUB, AND, OR).
  - cond_t enum (ALWAYS, NC, Z, NZ).
  - Select-width helper function.
- Sub-module td4x_alu: combinational, parametrised by WIDTH, taking (a, b, op) and producing {carry, result}.
- The top module holds the register array, OUT register, PC, flag flops, source mux, condition evaluation and write decode.

## Test plan
- Reset: assert CLR_N low between clock edges after arbitrary activity -> immediately OUT=0, PC=0, CARRY_N=1, ZERO=0; a subsequent read of reg0 via SRC=0 with ADD, IMMED=0 writing OUT -> OUT=0.
- Accumulate (WIDTH=4, NREGS=2): SRC=0, DST=0, ADD, IMMED=3, two cycles; then SRC=0, DST=2, IMMED=0 -> OUT=6; PC steps 0,1,2,3.
- Carry/JNC: reg0=0xF, ADD 1 -> reg0=0, CARRY_N=0, ZERO=1; next cycle SRC=3, DST=3, IMMED=5, COND=NC -> not taken, PC increments; after ADD 0 -> CARRY_N=1; repeat the jump -> PC=5.
- SUB: reg0=5, SUB 7 -> 0xE, CARRY_N=1, ZERO=0; reg0=7, SUB 7 -> 0, CARRY_N=0, ZERO=1; COND=Z jump to 9 -> PC=9.
- Wrap and enable: PC=15 with no PC write -> PC=0; EN=0 for 3 cycles with WE=1 -> all state unchanged.
- Illegal selects (NREGS=3, SEL_W=3): SRC=6 reads 0; DST=7 with WE=1 -> no register, OUT or PC load; PC increments, flags update.

Source files
------------

// File: rtl/td4x_pkg.sv
// td4x datapath shared types.
// ALU opcodes, write conditions and the select-width helper.
package td4x_pkg;

  typedef enum logic [1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    AND = 2'd2,
    OR  = 2'd3
  } alu_op_t;

  typedef enum logic [1:0] {
    ALWAYS = 2'd0,
    NC     = 2'd1,
    Z      = 2'd2,
    NZ     = 2'd3
  } cond_t;

  // Registers, the IN port and the constant-zero source share one select.
  function automatic int sel_width(input int nregs);
    return $clog2(nregs + 2);
  endfunction

endpackage

// File: rtl/td4x_alu.sv
// td4x ALU: combinational, result is {carry, value}.
// SUB adds the inverted immediate plus one, so carry means no borrow.
module td4x_alu
  import td4x_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  alu_op_t          op_i,
  output logic [WIDTH:0]   y_o
);

  always_comb begin
    y_o = '0;
    unique case (op_i)
      ADD: y_o = {1'b0, a_i} + {1'b0, b_i};
      SUB: y_o = {1'b0, a_i} + {1'b0, ~b_i}
               + (WIDTH+1)'(1);
      AND: y_o = {1'b0, a_i & b_i};
      OR:  y_o = {1'b0, a_i | b_i};
    endcase
  end

endmodule

// File: rtl/td4x_datapath.sv
// td4x datapath: register file, OUT port, PC and flags.
// Single-cycle; all state advances only on enabled cycles.
module td4x_datapath
  import td4x_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int NREGS = 2,
  parameter  int PC_W  = 4,
  localparam int SEL_W = sel_width(NREGS)
) (
  input  logic             CLK,
  input  logic             CLR_N,
  input  logic             EN,
  input  logic [SEL_W-1:0] SRC,
  input  logic [SEL_W-1:0] DST,
  input  logic             WE,
  input  logic [1:0]       ALU_OP,
  input  logic [1:0]       COND,
  input  logic [WIDTH-1:0] IN,
  input  logic [WIDTH-1:0] IMMED,
  output logic [WIDTH-1:0] OUT,
  output logic [PC_W-1:0]  PC,
  output logic             CARRY_N,
  output logic             ZERO
);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [WIDTH-1:0] out_q, out_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             carry_n_q, carry_n_d;
  logic             zero_q, zero_d;

  logic [WIDTH-1:0] opa;
  logic [WIDTH:0]   alu_y;
  logic [WIDTH-1:0] res;
  logic             cond_ok;
  logic             take;

  // Unmapped source codes fall through to zero.
  always_comb begin
    opa = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (SRC == SEL_W'(i)) opa = regs_q[i];
    end
    if (SRC == SEL_W'(NREGS)) opa = IN;
  end

  td4x_alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .a_i (opa),
    .b_i (IMMED),
    .op_i(alu_op_t'(ALU_OP)),
    .y_o (alu_y)
  );

  assign res = alu_y[WIDTH-1:0];

  always_comb begin
    cond_ok = 1'b0;
    unique case (cond_t'(COND))
      ALWAYS: cond_ok = 1'b1;
      NC:     cond_ok = carry_n_q;
      Z:      cond_ok = zero_q;
      NZ:     cond_ok = ~zero_q;
    endcase
  end

  assign take = WE & cond_ok;

  always_comb begin
    regs_d = regs_q;
    out_d  = out_q;
    pc_d   = pc_q + PC_W'(1);
    if (take) begin
      for (int i = 0; i < NREGS; i++) begin
        if (DST == SEL_W'(i)) regs_d[i] = res;
      end
      if (DST == SEL_W'(NREGS))   out_d = res;
      if (DST == SEL_W'(NREGS+1)) pc_d  = PC_W'(res);
    end
    carry_n_d = ~alu_y[WIDTH];
    zero_d    = (res == '0);
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      out_q     <= '0;
      pc_q      <= '0;
      carry_n_q <= 1'b1;
      zero_q    <= 1'b0;
    end else if (EN) begin
      regs_q    <= regs_d;
      out_q     <= out_d;
      pc_q      <= pc_d;
      carry_n_q <= carry_n_d;
      zero_q    <= zero_d;
    end
  end

  assign OUT     = out_q;
  assign PC      = pc_q;
  assign CARRY_N = carry_n_q;
  assign ZERO    = zero_q;

endmodule
